periph_pwm_multi: RTL and testbench

Parametrised multi-channel APB PWM peripheral. Provides NUM_CH independent PWM outputs driven by one shared prescaler, each with its own period, duty, polarity and enable. Period/duty updates are double-buffered and applied only at period boundaries, so outputs never glitch. A maskable period-end interrupt is also provided. The block sits on the APB peripheral bus beside the other PERI blocks; pwm_out drives pins directly.

---
 rtl/periph_pwm_multi.sv | 170 +++++++++++++++++
 tb/tb_periph_pwm_multi.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_pwm_multi.sv
// periph_pwm_multi
// Multi-channel APB PWM peripheral. One shared prescaler produces a tick
// every PRESC+1 PCLK cycles. Each channel counts ticks up to its active
// period and drives a registered PWM level. Period and duty are
// double-buffered: the active copies reload only when the channel wraps,
// or continuously while the channel is disabled.
//
// Ports
//   PCLK, PRESET            clock, async active-low reset
//   PADDR/PWRITE/PSEL/
//   PENABLE/PWDATA          APB request (PADDR[7:2] decoded)
//   PRDATA, PREADY          APB response, zero wait states
//   pwm_out[NUM_CH]         registered PWM outputs
//   irq                     level interrupt, |(IRQ_STAT & IRQ_EN)
module periph_pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [31:0]       PADDR,
  input  logic              PWRITE,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  localparam logic [5:0] A_CTRL     = 6'h00;
  localparam logic [5:0] A_PRESC    = 6'h01;
  localparam logic [5:0] A_CH_EN    = 6'h02;
  localparam logic [5:0] A_POL      = 6'h03;
  localparam logic [5:0] A_IRQ_EN   = 6'h04;
  localparam logic [5:0] A_IRQ_STAT = 6'h05;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic              r_gen;
  logic [CNT_W-1:0]  r_presc;
  logic [NUM_CH-1:0] r_ch_en;
  logic [NUM_CH-1:0] r_pol;
  logic [NUM_CH-1:0] r_irq_en;
  logic [NUM_CH-1:0] r_irq_stat;
  logic [CNT_W-1:0]  r_period   [NUM_CH];
  logic [CNT_W-1:0]  r_duty     [NUM_CH];
  logic [CNT_W-1:0]  r_pre_cnt;
  logic [CNT_W-1:0]  r_cnt      [NUM_CH];
  logic [CNT_W-1:0]  r_per_act  [NUM_CH];
  logic [CNT_W-1:0]  r_duty_act [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;

  logic [5:0]        w_word;
  logic              w_wr;
  logic              w_rd;
  logic              w_tick;
  logic [NUM_CH-1:0] w_act;
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_w1c;
  logic              w_unused;

  assign w_word = PADDR[7:2];
  assign w_wr   = PSEL & PENABLE & PWRITE;
  assign w_rd   = PSEL & ~PWRITE;
  // >= rather than == so lowering PRESC below the running count ticks at once
  assign w_tick = r_gen && (r_pre_cnt >= r_presc);
  assign w_act  = {NUM_CH{r_gen}} & r_ch_en;
  assign w_w1c  = (w_wr && (w_word == A_IRQ_STAT)) ? PWDATA[NUM_CH-1:0] : '0;

  assign PREADY   = 1'b1;
  assign pwm_out  = r_pwm;
  assign irq      = |(r_irq_stat & r_irq_en);
  assign w_unused = ^{PADDR[31:8], PADDR[1:0], PWDATA};

  always_comb begin
    w_wrap = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_wrap[n] = w_act[n] && w_tick && (r_cnt[n] == r_per_act[n]);
    end
  end

  // Register file
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_gen      <= 1'b0;
      r_presc    <= '0;
      r_ch_en    <= '0;
      r_pol      <= '0;
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        r_period[n] <= '0;
        r_duty[n]   <= '0;
      end
    end else begin
      if (w_wr) begin
        case (w_word)
          A_CTRL:   r_gen    <= PWDATA[0];
          A_PRESC:  r_presc  <= PWDATA[CNT_W-1:0];
          A_CH_EN:  r_ch_en  <= PWDATA[NUM_CH-1:0];
          A_POL:    r_pol    <= PWDATA[NUM_CH-1:0];
          A_IRQ_EN: r_irq_en <= PWDATA[NUM_CH-1:0];
          default: ;
        endcase
        for (int n = 0; n < NUM_CH; n++) begin
          if (w_word == 6'(8 + 2 * n)) r_period[n] <= PWDATA[CNT_W-1:0];
          if (w_word == 6'(9 + 2 * n)) r_duty[n]   <= PWDATA[CNT_W-1:0];
        end
      end
      // a wrap in the same cycle as a clear keeps the bit set
      r_irq_stat <= (r_irq_stat & ~w_w1c) | w_wrap;
    end
  end

  // Prescaler
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_pre_cnt <= '0;
    end else if (!r_gen || w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + C_ONE;
    end
  end

  // Channel counters, active copies and output levels
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_pwm <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        r_cnt[n]      <= '0;
        r_per_act[n]  <= '0;
        r_duty_act[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_pwm[n] <= w_act[n] ? ((r_cnt[n] < r_duty_act[n]) ^ r_pol[n]) : r_pol[n];
        if (!w_act[n] || w_wrap[n]) begin
          r_cnt[n]      <= '0;
          r_per_act[n]  <= r_period[n];
          r_duty_act[n] <= r_duty[n];
        end else if (w_tick) begin
          r_cnt[n] <= r_cnt[n] + C_ONE;
        end
      end
    end
  end

  // Read mux, combinational while selected for read
  always_comb begin
    PRDATA = '0;
    if (w_rd) begin
      case (w_word)
        A_CTRL:     PRDATA = {31'b0, r_gen};
        A_PRESC:    PRDATA = 32'(r_presc);
        A_CH_EN:    PRDATA = 32'(r_ch_en);
        A_POL:      PRDATA = 32'(r_pol);
        A_IRQ_EN:   PRDATA = 32'(r_irq_en);
        A_IRQ_STAT: PRDATA = 32'(r_irq_stat);
        default: ;
      endcase
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_word == 6'(8 + 2 * n)) PRDATA = 32'(r_period[n]);
        if (w_word == 6'(9 + 2 * n)) PRDATA = 32'(r_duty[n]);
      end
    end
  end

endmodule

// File: tb/tb_periph_pwm_multi.sv
// Bench for periph_pwm_multi: a default (4 ch, 16 bit) instance and a wide
// (8 ch, 32 bit) instance share one APB bus. A behavioural model built from
// the register rules is compared against both on every cycle, and directed
// sequences pin the model with hand-computed waveform properties.
module tb_periph_pwm_multi;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA, PRDATA2;
  logic        PREADY, PREADY2;
  logic [3:0]  pwm_out;
  logic [7:0]  pwm_out2;
  logic        irq, irq2;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  periph_pwm_multi #(.NUM_CH(4), .CNT_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .pwm_out(pwm_out), .irq(irq));

  periph_pwm_multi #(.NUM_CH(8), .CNT_W(32)) dut_w8 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA2), .PREADY(PREADY2),
    .pwm_out(pwm_out2), .irq(irq2));

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_gen = 1'b0;
  logic [15:0] m_presc = '0, m_pre = '0;
  logic [3:0]  m_chen = '0, m_pol = '0, m_ien = '0, m_istat = '0, m_pwm = '0;
  int          m_per [4] = '{0, 0, 0, 0};
  int          m_duty[4] = '{0, 0, 0, 0};
  int          m_pos [4] = '{0, 0, 0, 0};   // ticks elapsed in current period
  int          m_plen[4] = '{0, 0, 0, 0};   // period in effect (PERIOD+1 ticks)
  int          m_high[4] = '{0, 0, 0, 0};   // high ticks in effect
  logic        m_tick;
  logic [3:0]  m_wrapped, m_next_pwm;

  always @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      m_gen = 0; m_presc = 0; m_pre = 0; m_chen = 0; m_pol = 0;
      m_ien = 0; m_istat = 0; m_pwm = 0;
      for (int c = 0; c < 4; c++) begin
        m_per[c] = 0; m_duty[c] = 0; m_pos[c] = 0; m_plen[c] = 1; m_high[c] = 0;
      end
    end else begin
      m_tick = m_gen && (m_pre >= m_presc);
      m_wrapped = '0;
      for (int c = 0; c < 4; c++) begin
        if (m_gen && m_chen[c]) begin
          m_next_pwm[c] = (m_pos[c] < m_high[c]) ^ m_pol[c];
          if (m_tick) begin
            if (m_pos[c] + 1 == m_plen[c]) begin
              m_pos[c] = 0; m_wrapped[c] = 1'b1;
              m_plen[c] = m_per[c] + 1; m_high[c] = m_duty[c];
            end else m_pos[c] = m_pos[c] + 1;
          end
        end else begin
          m_next_pwm[c] = m_pol[c];
          m_pos[c] = 0; m_plen[c] = m_per[c] + 1; m_high[c] = m_duty[c];
        end
      end
      m_pwm = m_next_pwm;
      m_pre = (!m_gen || m_tick) ? 16'd0 : m_pre + 16'd1;
      if (PSEL && PENABLE && PWRITE) begin
        case (PADDR[7:0])
          8'h00: m_gen = PWDATA[0];
          8'h04: m_presc = PWDATA[15:0];
          8'h08: m_chen = PWDATA[3:0];
          8'h0C: m_pol = PWDATA[3:0];
          8'h10: m_ien = PWDATA[3:0];
          8'h14: m_istat = m_istat & ~PWDATA[3:0];
          default:
            if (PADDR[7:0] >= 8'h20 && PADDR[7:0] < 8'h40) begin
              if (PADDR[2]) m_duty[(PADDR[7:0] - 8'h20) >> 3] = int'(PWDATA[15:0]);
              else          m_per [(PADDR[7:0] - 8'h20) >> 3] = int'(PWDATA[15:0]);
            end
        endcase
      end
      m_istat = m_istat | m_wrapped;
    end
  end

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return {31'b0, m_gen};
      8'h04: return {16'b0, m_presc};
      8'h08: return {28'b0, m_chen};
      8'h0C: return {28'b0, m_pol};
      8'h10: return {28'b0, m_ien};
      8'h14: return {28'b0, m_istat};
      default:
        if (a >= 8'h20 && a < 8'h40)
          return a[2] ? 32'(m_duty[(a - 8'h20) >> 3]) : 32'(m_per[(a - 8'h20) >> 3]);
        else return 32'h0;
    endcase
  endfunction

  // per-cycle comparison, away from the active edge
  always @(negedge PCLK) begin
    if (chk_en) begin
      check("pwm_out", {60'b0, pwm_out}, {60'b0, m_pwm});
      check("pwm_out_w8", {56'b0, pwm_out2}, {60'b0, m_pwm});
      check("irq", {63'b0, irq}, {63'b0, |(m_istat & m_ien)});
      check("irq_w8", {63'b0, irq2}, {63'b0, |(m_istat & m_ien)});
    end
  end

  // ---------------- bus tasks ----------------
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {24'h0, a}; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // reads both instances, compares against the model and returns the value
  task automatic check_reg(input logic [7:0] a, output logic [31:0] d);
    logic [31:0] e;
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {24'h0, a};
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    e = m_read(a);
    check($sformatf("read_%02h", a), {32'b0, PRDATA}, {32'b0, e});
    check($sformatf("read_w8_%02h", a), {32'b0, PRDATA2}, {32'b0, e});
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic count_high(input int ch, input int cycles, output int highs);
    highs = 0;
    repeat (cycles) begin
      @(negedge PCLK);
      if (pwm_out[ch]) highs++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  seq;
    int          hi, k;
    logic [7:0]  regs [14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                               8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C};

    // reset state
    repeat (3) @(negedge PCLK);
    check("rst_pwm", {60'b0, pwm_out}, 64'h0);
    check("rst_irq", {63'b0, irq}, 64'h0);
    check("rst_pready", {62'b0, PREADY2, PREADY}, 64'h3);
    PRESET = 1'b1;
    chk_en = 1'b1;

    // basic waveform: PRESC=0, PERIOD_0=3, DUTY_0=1 -> 1,0,0,0 repeating
    apb_write(8'h04, 0);
    apb_write(8'h20, 3);
    apb_write(8'h24, 1);
    apb_write(8'h0C, 0);
    apb_write(8'h08, 1);
    apb_write(8'h00, 1);
    seq = '0;
    repeat (8) begin
      @(negedge PCLK);
      seq = {seq[6:0], pwm_out[0]};
    end
    check("basic_pattern", {56'b0, seq}, 64'h88);
    check_reg(8'h14, rd);
    check("basic_irq_stat", {32'b0, rd}, 64'h1);

    // prescaler: PRESC=2, PERIOD_1=4, DUTY_1=2 -> 15 PCLK period, 6 high
    apb_write(8'h00, 0);
    apb_write(8'h04, 2);
    apb_write(8'h28, 4);
    apb_write(8'h2C, 2);
    apb_write(8'h08, 2);
    apb_write(8'h00, 1);
    @(negedge PCLK);
    count_high(1, 30, hi);
    check("presc_high_30", 64'(hi), 64'd12);
    apb_write(8'h0C, 2);
    count_high(1, 30, hi);
    check("pol_high_30", 64'(hi), 64'd18);
    apb_write(8'h08, 0);
    @(negedge PCLK);
    check("pol_idle", {63'b0, pwm_out[1]}, 64'h1);
    apb_write(8'h0C, 0);

    // double buffering: DUTY_0 1 -> 3 written mid-period
    apb_write(8'h00, 0);
    apb_write(8'h04, 0);
    apb_write(8'h20, 3);
    apb_write(8'h24, 1);
    apb_write(8'h08, 1);
    apb_write(8'h00, 1);
    seq = '0;
    fork
      apb_write(8'h24, 3);
      repeat (8) begin
        @(negedge PCLK);
        seq = {seq[6:0], pwm_out[0]};
      end
    join
    check("dbuf_pattern", {56'b0, seq}, 64'h8E);
    apb_write(8'h24, 0);
    repeat (8) @(negedge PCLK);
    count_high(0, 8, hi);
    check("duty0_low", 64'(hi), 64'd0);
    apb_write(8'h24, 5);
    repeat (8) @(negedge PCLK);
    count_high(0, 8, hi);
    check("duty_gt_per_high", 64'(hi), 64'd8);

    // interrupt on channel 2
    apb_write(8'h00, 0);
    apb_write(8'h14, 32'hF);
    apb_write(8'h10, 4);
    apb_write(8'h30, 3);
    apb_write(8'h34, 1);
    apb_write(8'h08, 4);
    check("irq_idle", {63'b0, irq}, 64'h0);
    apb_write(8'h00, 1);
    k = 0;
    while (!irq && k < 10) begin
      @(negedge PCLK);
      k++;
    end
    check("irq_latency", 64'(k), 64'd4);
    apb_write(8'h14, 4);
    check("irq_w1c", {63'b0, irq}, 64'h0);
    k = 0;
    while (!irq && k < 10) begin
      @(negedge PCLK);
      k++;
    end
    check("irq_rearm", 64'(k), 64'd1);
    @(negedge PCLK);
    apb_write(8'h14, 4);          // commits on the next wrap edge
    check("irq_set_wins", {63'b0, irq}, 64'h1);
    check_reg(8'h14, rd);
    check("irq_stat_set_wins", {32'b0, rd}, 64'h4);

    // unmapped addresses
    apb_write(8'h18, 32'hFFFF_FFFF);
    apb_write(8'h7C, 32'hFFFF_FFFF);
    check_reg(8'h18, rd);
    check("unmapped_18", {32'b0, rd}, 64'h0);
    check_reg(8'h7C, rd);
    check("unmapped_7c", {32'b0, rd}, 64'h0);
    for (int i = 0; i < 14; i++) check_reg(regs[i], rd);

    // PRESC lowered from 100 to 3 while pre_cnt is 50
    apb_write(8'h00, 0);
    apb_write(8'h08, 1);
    apb_write(8'h20, 3);
    apb_write(8'h24, 1);
    apb_write(8'h04, 100);
    apb_write(8'h00, 1);
    repeat (48) @(negedge PCLK);
    apb_write(8'h04, 3);
    k = 0;
    while (pwm_out[0] && k < 10) begin
      @(negedge PCLK);
      k++;
    end
    check("presc_drop_latency", 64'(k), 64'd2);

    // asynchronous reset mid-run
    apb_write(8'h08, 0);
    apb_write(8'h0C, 32'hF);
    @(negedge PCLK);
    check("pre_rst_pwm", {60'b0, pwm_out}, 64'hF);
    check("pre_rst_irq", {63'b0, irq}, 64'h1);
    @(posedge PCLK);
    #3;
    PRESET = 1'b0;
    #1;
    check("arst_pwm", {60'b0, pwm_out}, 64'h0);
    check("arst_pwm_w8", {56'b0, pwm_out2}, 64'h0);
    check("arst_irq", {62'b0, irq2, irq}, 64'h0);
    check("arst_pready", {62'b0, PREADY2, PREADY}, 64'h3);
    PSEL = 1'b1; PWRITE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      PADDR = {24'h0, regs[i]};
      #1;
      check($sformatf("arst_read_%02h", regs[i]), {PRDATA2, PRDATA}, 64'h0);
    end
    PSEL = 1'b0;
    #1;
    check("arst_prdata_unsel", {PRDATA2, PRDATA}, 64'h0);
    @(negedge PCLK);
    PRESET = 1'b1;
    repeat (4) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
